// File: rtl/gb_int_ctrl_if.sv
// CPU-side bus, interrupt handshake and source request bundle for the interrupt controller.
// The CPU/bench drives the master side; the controller is the slave.
interface gb_int_ctrl_if;
  logic [15:0] addr;
  logic [7:0]  wr_data;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  rd_data;
  logic        rd_oe;
  logic [4:0]  irq_src;
  logic        ime;
  logic        int_ack;
  logic        int_n;
  logic [2:0]  int_id;
  logic [7:0]  int_vector;

  modport master (
    output addr, wr_data, rd_n, wr_n, irq_src, ime, int_ack,
    input  rd_data, rd_oe, int_n, int_id, int_vector
  );

  modport slave (
    input  addr, wr_data, rd_n, wr_n, irq_src, ime, int_ack,
    output rd_data, rd_oe, int_n, int_id, int_vector
  );
endinterface

// File: rtl/gb_int_ctrl.sv
// Game Boy style interrupt controller: edge-latches five sources into IF, masks them with IE
// and presents the highest-priority pending request to the CPU on int_n with its vector.
module gb_int_ctrl #(
  parameter int          HOLDOFF_CYCLES = 4,
  parameter logic [7:0]  VEC_BASE       = 8'h40
) (
  input  logic         clk,
  input  logic         rst_n,
  gb_int_ctrl_if.slave bus
);

  localparam int CW = (HOLDOFF_CYCLES < 2) ? 1 : $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [4:0]     r_if;
  logic [4:0]     w_ifNext;
  logic [7:0]     r_ie;
  logic [4:0]     r_srcQ;
  logic           r_intN;
  logic           w_intNNext;
  logic [2:0]     r_intId;
  logic [2:0]     w_intIdNext;
  logic [7:0]     r_intVector;
  logic [7:0]     w_intVectorNext;
  logic [CW-1:0]  r_hold;
  logic [CW-1:0]  w_holdNext;

  logic [4:0]     w_rise;
  logic           w_wrIf;
  logic           w_wrIe;
  logic           w_selIf;
  logic           w_selIe;
  logic [4:0]     w_ackClear;
  logic [4:0]     w_pending;
  logic           w_anyPending;
  logic [2:0]     w_winner;

  assign w_rise  = bus.irq_src & ~r_srcQ;
  assign w_selIf = (bus.addr == 16'hFF0F);
  assign w_selIe = (bus.addr == 16'hFFFF);
  assign w_wrIf  = !bus.wr_n && w_selIf;
  assign w_wrIe  = !bus.wr_n && w_selIe;

  // An ack only clears the latched source while a request is actually being presented.
  assign w_ackClear = (r_state == ASSERT && bus.int_ack) ? (5'b00001 << r_intId) : 5'b00000;

  // A fresh rising edge wins over both a software write and an ack clear on the same edge.
  assign w_ifNext = ((w_wrIf ? bus.wr_data[4:0] : r_if) & ~w_ackClear) | w_rise;

  assign w_pending    = r_if & r_ie[4:0];
  assign w_anyPending = |w_pending;

  always_comb begin
    w_winner = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (w_pending[i]) w_winner = 3'(i);
    end
  end

  assign bus.rd_oe   = !bus.rd_n && (w_selIf || w_selIe);
  assign bus.rd_data = !bus.rd_oe ? 8'h00 :
                       w_selIf    ? {3'b111, r_if} : r_ie;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_srcQ <= 5'h00;
      r_if   <= 5'h00;
      r_ie   <= 8'h00;
    end else begin
      r_srcQ <= bus.irq_src;
      r_if   <= w_ifNext;
      if (w_wrIe) r_ie <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_intN      <= 1'b1;
      r_intId     <= 3'd0;
      r_intVector <= 8'h00;
      r_hold      <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_intN      <= w_intNNext;
      r_intId     <= w_intIdNext;
      r_intVector <= w_intVectorNext;
      r_hold      <= w_holdNext;
    end
  end

  // id/vector are latched on entry to ASSERT and left stale afterwards; a newly arriving
  // higher-priority source cannot pre-empt the request already presented.
  always_comb begin
    w_stateNext     = r_state;
    w_intNNext      = r_intN;
    w_intIdNext     = r_intId;
    w_intVectorNext = r_intVector;
    w_holdNext      = r_hold;
    case (r_state)
      IDLE: begin
        if (bus.ime && w_anyPending) begin
          w_intIdNext     = w_winner;
          w_intVectorNext = VEC_BASE + {2'b00, w_winner, 3'b000};
          w_intNNext      = 1'b0;
          w_stateNext     = ASSERT;
        end
      end
      ASSERT: begin
        if (bus.int_ack) begin
          w_intNNext  = 1'b1;
          w_holdNext  = CW'(HOLDOFF_CYCLES);
          w_stateNext = HOLDOFF;
        end else if (!w_pending[r_intId] || !bus.ime) begin
          w_intNNext  = 1'b1;
          w_stateNext = IDLE;
        end
      end
      HOLDOFF: begin
        w_intNNext = 1'b1;
        if (r_hold <= CW'(1)) begin
          w_holdNext  = '0;
          w_stateNext = IDLE;
        end else begin
          w_holdNext = r_hold - CW'(1);
        end
      end
      default: begin
        w_intNNext  = 1'b1;
        w_stateNext = IDLE;
      end
    endcase
  end

  assign bus.int_n      = r_intN;
  assign bus.int_id     = r_intId;
  assign bus.int_vector = r_intVector;

endmodule
